// File: rtl/any1_pkg.sv
// Shared types for the branch resolve queue: address type, queue entry layout, default depth.
package any1_pkg;

    localparam int ADDR_W    = 32;
    localparam int BRQ_DEPTH = 8;

    typedef logic [ADDR_W-1:0] Address;

    typedef struct packed {
        Address ip;
        logic   pred_taken;
        Address pred_tgt;
    } brq_entry_t;

endpackage

// File: rtl/any1_brq_ram.sv
// Entry storage for the branch resolve queue: one synchronous write port, asynchronous read.
module any1_brq_ram
    import any1_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  brq_entry_t    wdata,
    input  logic [PW-1:0] raddr,
    output brq_entry_t    rdata
);

    brq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves the head against execute, drives predictor update
// and a registered fetch redirect. Optional BRQ_STATS_EN adds resolved/mispredict counters.
module branch_resolve_queue
    import any1_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          f_push,
    input  Address        f_ip,
    input  logic          f_pred_taken,
    input  Address        f_pred_tgt,
    output logic          f_rdy,
    input  logic          x_valid,
    input  logic          x_takb,
    input  Address        x_tgt,
    input  Address        x_fallthru,
    output logic          x_rdy,
    output logic          xisBranch,
    output Address        xip,
    output logic          takb,
    output logic          mispredict,
    output Address        redirect_ip,
    output logic [CW-1:0] count,
    output logic          err_underflow
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]   stat_resolved,
    output logic [31:0]   stat_mispredict
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          xisb_q, xisb_d, takb_q, takb_d, mis_q, mis_d, err_q, err_d;
    Address        xip_q, xip_d, redir_q, redir_d;

    brq_entry_t head, wentry;
    logic       full, do_pop, do_push, miss, flush, wr_en;
    Address     correct;

    any1_brq_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wentry),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    always_comb begin
        wentry  = '{ip: f_ip, pred_taken: f_pred_taken, pred_tgt: f_pred_tgt};
        full    = (count_q == CW'(DEPTH));
        do_pop  = en & x_valid & (count_q != '0);
        miss    = (head.pred_taken != x_takb) |
                  (x_takb & head.pred_taken & (head.pred_tgt != x_tgt));
        correct = x_takb ? x_tgt : x_fallthru;
        flush   = do_pop & miss;
        // A full queue still takes a push when the head leaves in the same cycle.
        do_push = en & f_push & ~mis_q & (~full | do_pop);
        wr_en   = do_push & ~flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (wr_en)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        xisb_d  = do_pop;
        mis_d   = flush;
        xip_d   = do_pop ? head.ip : xip_q;
        takb_d  = do_pop ? x_takb  : takb_q;
        redir_d = do_pop ? correct : redir_q;
        err_d   = err_q | (en & x_valid & (count_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            xisb_q   <= 1'b0;
            mis_q    <= 1'b0;
            xip_q    <= '0;
            takb_q   <= 1'b0;
            redir_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            xisb_q   <= xisb_d;
            mis_q    <= mis_d;
            xip_q    <= xip_d;
            takb_q   <= takb_d;
            redir_q  <= redir_d;
            err_q    <= err_d;
        end
    end

    assign f_rdy         = ~full;
    assign x_rdy         = (count_q != '0);
    assign count         = count_q;
    assign xisBranch     = xisb_q;
    assign mispredict    = mis_q;
    assign xip           = xip_q;
    assign takb          = takb_q;
    assign redirect_ip   = redir_q;
    assign err_underflow = err_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;

    always_comb begin
        stat_res_d = stat_res_q + {31'd0, xisb_q};
        stat_mis_d = stat_mis_q + {31'd0, mis_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_res_q <= stat_res_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_resolved   = stat_res_q;
    assign stat_mispredict = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed table, corner sequences, random vs queue model.
module tb_branch_resolve_queue;
    import any1_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, f_push, f_pred_taken, x_valid, x_takb;
    logic [31:0]   f_ip, f_pred_tgt, x_tgt, x_fallthru;
    logic          f_rdy, x_rdy, xisBranch, takb, mispredict, err_underflow;
    logic [31:0]   xip, redirect_ip;
    logic [CW-1:0] count;
`ifdef BRQ_STATS_EN
    logic [31:0]   stat_resolved, stat_mispredict;
`endif

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .f_push(f_push), .f_ip(f_ip), .f_pred_taken(f_pred_taken), .f_pred_tgt(f_pred_tgt),
        .f_rdy(f_rdy),
        .x_valid(x_valid), .x_takb(x_takb), .x_tgt(x_tgt), .x_fallthru(x_fallthru),
        .x_rdy(x_rdy),
        .xisBranch(xisBranch), .xip(xip), .takb(takb), .mispredict(mispredict),
        .redirect_ip(redirect_ip), .count(count), .err_underflow(err_underflow)
`ifdef BRQ_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
`endif
    );

    typedef struct {
        logic [31:0] ip;
        logic        pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic        m_xisb, m_takb, m_mis, m_err;
    logic [31:0] m_xip, m_red;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_xisb = 0; m_takb = 0; m_mis = 0; m_err = 0;
        m_xip = 0; m_red = 0;
    endtask

    // Behavioural model: queue semantics evaluated from the inputs present before the edge.
    task automatic model_step();
        int   sz;
        bit   pop, push, miss;
        ent_t h;
        sz   = mq.size();
        pop  = en && x_valid && sz > 0;
        push = en && f_push && !m_mis && (sz < DEPTH || pop);
        miss = 0;
        if (en && x_valid && sz == 0) m_err = 1;
        m_xisb = 0;
        m_mis  = 0;
        if (pop) begin
            h      = mq.pop_front();
            miss   = (h.pt != x_takb) || (x_takb && h.pt && h.tgt != x_tgt);
            m_xisb = 1;
            m_xip  = h.ip;
            m_takb = x_takb;
            m_mis  = miss;
            m_red  = x_takb ? x_tgt : x_fallthru;
            if (miss) mq.delete();
        end
        if (push && !miss) mq.push_back('{f_ip, f_pred_taken, f_pred_tgt});
    endtask

    task automatic check_model();
        chk("m_count", count, mq.size());
        chk("m_f_rdy", f_rdy, mq.size() < DEPTH);
        chk("m_x_rdy", x_rdy, mq.size() > 0);
        chk("m_xisBranch", xisBranch, m_xisb);
        chk("m_mispredict", mispredict, m_mis);
        chk("m_xip", xip, m_xip);
        chk("m_takb", takb, m_takb);
        chk("m_redirect_ip", redirect_ip, m_red);
        chk("m_err_underflow", err_underflow, m_err);
    endtask

    task automatic cyc(input bit e, input bit fp, input logic [31:0] fip, input bit fpt,
                       input logic [31:0] ftgt, input bit xv, input bit xt,
                       input logic [31:0] xtg, input logic [31:0] xft);
        en = e; f_push = fp; f_ip = fip; f_pred_taken = fpt; f_pred_tgt = ftgt;
        x_valid = xv; x_takb = xt; x_tgt = xtg; x_fallthru = xft;
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          e, fp;
        logic [31:0] fip;
        bit          fpt;
        logic [31:0] ftgt;
        bit          xv, xt;
        logic [31:0] xtg, xft;
        int          ecnt;
        bit          exisb, emis;
        logic [31:0] exip, ered;
    } vec_t;

    vec_t tv[14];

    initial begin
        tv[0]  = '{1, 1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h0,   32'h0};
        tv[1]  = '{1, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   32'h104, 0, 1, 0, 32'h100, 32'h104};
        tv[2]  = '{1, 1, 32'h200, 1, 32'h400, 0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h100, 32'h104};
        tv[3]  = '{1, 0, 32'h0,   0, 32'h0,   1, 1, 32'h480, 32'h204, 0, 1, 1, 32'h200, 32'h480};
        tv[4]  = '{1, 1, 32'h300, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h200, 32'h480};
        tv[5]  = '{1, 1, 32'h500, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h200, 32'h480};
        tv[6]  = '{1, 1, 32'h504, 1, 32'h600, 0, 0, 32'h0,   32'h0,   2, 0, 0, 32'h200, 32'h480};
        tv[7]  = '{1, 1, 32'h508, 0, 32'h0,   0, 0, 32'h0,   32'h0,   3, 0, 0, 32'h200, 32'h480};
        tv[8]  = '{1, 1, 32'h50c, 0, 32'h0,   1, 1, 32'h800, 32'h504, 0, 1, 1, 32'h500, 32'h800};
        tv[9]  = '{1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h500, 32'h800};
        tv[10] = '{1, 1, 32'h700, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 0, 0, 32'h500, 32'h800};
        tv[11] = '{0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   32'h704, 1, 0, 0, 32'h500, 32'h800};
        tv[12] = '{1, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   32'h704, 0, 1, 0, 32'h700, 32'h704};
        tv[13] = '{0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h700, 32'h704};

        rst = 1'b1;
        en = 0; f_push = 0; f_ip = 0; f_pred_taken = 0; f_pred_tgt = 0;
        x_valid = 0; x_takb = 0; x_tgt = 0; x_fallthru = 0;
        model_reset();
        #2;
        chk("rst_count", count, 0);
        chk("rst_f_rdy", f_rdy, 1);
        chk("rst_x_rdy", x_rdy, 0);
        chk("rst_xisBranch", xisBranch, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_xip", xip, 0);
        chk("rst_redirect_ip", redirect_ip, 0);
        chk("rst_err", err_underflow, 0);
        #10 rst = 1'b0;

        // Directed table: basic resolve, target miss, flush with dropped pushes, en hold.
        for (int i = 0; i < 14; i++) begin
            cyc(tv[i].e, tv[i].fp, tv[i].fip, tv[i].fpt, tv[i].ftgt,
                tv[i].xv, tv[i].xt, tv[i].xtg, tv[i].xft);
            chk($sformatf("tv%0d_count", i), count, tv[i].ecnt);
            chk($sformatf("tv%0d_xisBranch", i), xisBranch, tv[i].exisb);
            chk($sformatf("tv%0d_mispredict", i), mispredict, tv[i].emis);
            chk($sformatf("tv%0d_xip", i), xip, tv[i].exip);
            chk($sformatf("tv%0d_redirect", i), redirect_ip, tv[i].ered);
        end

        // Fill to full, ignored ninth push, push+pop while full across the wrap.
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 32'h1000 + 4*i, 0, 0, 0, 0, 0, 0);
        chk("full_f_rdy", f_rdy, 0);
        chk("full_count", count, DEPTH);
        cyc(1, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
        chk("full_ninth_count", count, DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1, 1, 32'h3000 + 4*k, 0, 0, 1, 0, 0, 32'h1004 + 4*k);
            chk("full_pp_count", count, DEPTH);
            chk("full_pp_xip", xip, 32'h1000 + 4*k);
        end
        for (int k = 0; k < DEPTH; k++) begin
            cyc(1, 0, 0, 0, 0, 1, 0, 0, 32'h3004 + 4*k);
            chk("drain_xip", xip, 32'h3000 + 4*k);
        end
        chk("drain_count", count, 0);
        chk("drain_x_rdy", x_rdy, 0);

        // Underflow sets a sticky flag and leaves outputs alone.
        cyc(1, 0, 0, 0, 0, 1, 1, 32'h44, 32'h48);
        chk("uf_err", err_underflow, 1);
        chk("uf_xisBranch", xisBranch, 0);
        chk("uf_xip", xip, 32'h301c);
        cyc(1, 1, 32'h900, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 32'h904);
        chk("uf_after_xisBranch", xisBranch, 1);
        chk("uf_after_xip", xip, 32'h900);
        chk("uf_sticky", err_underflow, 1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 8) != 0, $urandom % 2, $urandom & 32'hfffc, $urandom % 2,
                ($urandom % 2) ? 32'h40 : 32'h80, ($urandom % 3) == 0, $urandom % 2,
                ($urandom % 2) ? 32'h40 : 32'h80, $urandom & 32'hfffc);
        end

        // Async reset with five entries and a resolve pending.
        if (mq.size() > 0) cyc(1, 0, 0, 0, 0, 1, !mq[0].pt, 32'h0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'ha00 + 4*i, 1, 32'hb00, 0, 0, 0, 0);
        chk("prerst_count", count, 5);
        en = 1; x_valid = 1; x_takb = 1; x_tgt = 32'hc00; x_fallthru = 32'ha04;
        #3;
        rst = 1'b1;
        x_valid = 0;
        #1;
        model_reset();
        chk("arst_count", count, 0);
        chk("arst_f_rdy", f_rdy, 1);
        chk("arst_xisBranch", xisBranch, 0);
        chk("arst_mispredict", mispredict, 0);
        chk("arst_xip", xip, 0);
        chk("arst_takb", takb, 0);
        chk("arst_redirect_ip", redirect_ip, 0);
        chk("arst_err", err_underflow, 0);
        #2 rst = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_xisBranch", xisBranch, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
Sits between the fetch stage and the execute stage, directly upstream of the gselect predictor.
- Holds an in-order queue of predicted branches pushed at fetch: IP, predicted direction and predicted target.
- When execute resolves each branch in order, it pops the head entry and compares the real outcome against the prediction.
- Drives the predictor's update interface (xisBranch/xip/takb), plus a registered mispredict/redirect to fetch.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 2.
CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
en  in  1  pipeline advance; when low, no push, pop or output update
f_push  in  1  fetch presents a predicted branch
f_ip  in  Address  IP of the fetched branch
f_pred_taken  in  1  predictor's predict_taken for that IP
f_pred_tgt  in  Address  predicted target; meaningful only when f_pred_taken=1
f_rdy  out  1  queue can accept a push (not full)
x_valid  in  1  execute resolves the oldest outstanding branch
x_takb  in  1  actual direction
x_tgt  in  Address  actual taken target
x_fallthru  in  Address  sequential next IP of the branch
x_rdy  out  1  queue non-empty
xisBranch  out  1  predictor update strobe
xip  out  Address  IP of the resolved branch
takb  out  1  resolved direction
mispredict  out  1  redirect fetch this cycle
redirect_ip  out  Address  correct next IP
count  out  CW  current occupancy
err_underflow  out  1  sticky flag: resolve arrived while the queue was empty

Behaviour:
Reset:
- Pointers and count are 0.
- All outputs are 0, redirect_ip and xip included; f_rdy=1; err_underflow=0.

Push and pop:
- A push is accepted when en & f_push & f_rdy & ~mispredict. A push while full is ignored; fetch must hold.
- A pop happens when en & x_valid & x_rdy.
- A simultaneous push and pop in the same cycle leaves count unchanged, including when full or when count=1.
- Pointers wrap modulo DEPTH.

Resolve (combinational, on the head entry in the pop cycle):
- miss = (head.pred_taken != x_takb) | (x_takb & head.pred_taken & head.pred_tgt != x_tgt).
- correct = x_takb ? x_tgt : x_fallthru.

Registered outputs (one cycle after the pop):
- xisBranch=1, xip=head.ip, takb=x_takb.
- mispredict=miss, redirect_ip=correct.
- xisBranch and mispredict are single-cycle pulses. xip, takb and redirect_ip hold their values until the next pop.
- With en low, the outputs hold their values but xisBranch and mispredict deassert.

Flush on miss:
- In the pop cycle, the queue is emptied (rd=wr, count=0) and any simultaneous push is dropped.
- In the following cycle, while mispredict=1, pushes are still dropped as wrong-path.

Underflow:
- x_valid while empty: no pop, outputs unaffected, err_underflow set. It clears only on rst.

Async reset mid-operation:
- Discards all entries immediately.
- A pulse in flight is not emitted.

Optional Feature:
Macro BRQ_STATS_EN.
- Defined: two 32-bit outputs, stat_resolved and stat_mispredict.
  - Each increments on a registered xisBranch / mispredict pulse.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical in both cases.

Decomposition:
Shared package any1_pkg:
- typedef brq_entry_t {Address ip; logic pred_taken; Address pred_tgt;}
- localparam BRQ_DEPTH = 8.

Sub-module any1_brq_ram:
- DEPTH x brq_entry_t storage, 1 write port, asynchronous read.
- Pointer, count and flush control stay in the top module.

Test Plan:
1. Push IP 0x100 (pred_taken=0); resolve x_takb=0, x_fallthru=0x104. Next cycle: xisBranch=1, xip=0x100, takb=0, mispredict=0, count=0.
2. Push 0x200 (pred_taken=1, tgt=0x400); resolve x_takb=1, x_tgt=0x480 -> mispredict=1, redirect_ip=0x480. Target mismatch counts as a miss.
3. Push 3 entries, the first predicted not-taken; resolve it taken (x_tgt=0x800) with a simultaneous push -> mispredict=1, redirect_ip=0x800, count=0. The push in the mispredict cycle is also dropped.
4. Push 8 entries -> f_rdy=0, count=8. A ninth push is ignored. Simultaneous push+pop while full -> count stays 8, FIFO order preserved across wrap.
5. x_valid with an empty queue -> err_underflow=1, xisBranch stays 0. Subsequent normal traffic works; the flag stays set until rst.
6. Assert rst asynchronously mid-cycle with count=5 and a resolve pending -> count=0 and all outputs 0 immediately, with no xisBranch pulse after release.
